// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file and writeback-source constants for the writeback arbiter.
// These values are used by regfile_wb_arbiter and regfile_wb_arbiter_rr_pick.
package regfile_wb_arbiter_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // Writeback requester indices, used as positions in the request vectors.
   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_MEM = 1;
   localparam int WB_SRC_MDU = 2;

   // After reset, last_ptr points at the highest requester so requester 0 wins first.
   function automatic logic [1:0] rst_ptr(input int nreq);
      return 2'(nreq - 1);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search starts one position past last_ptr and wraps around.
// The first valid requester found gets a one-hot grant and its encoded index.
// When no request is valid, both outputs are zero.
module regfile_wb_arbiter_rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] valid,
   input  logic [1:0]      last_ptr,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      idx
);

   localparam int IW = $clog2(NREQ);

   int   cand;
   logic found;

   // Walk the requesters in priority order starting after last_ptr; the first valid one wins.
   always_comb begin
      grant = '0;
      idx   = 2'd0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_ptr) + k) % NREQ;
         if (!found && valid[cand[IW-1:0]]) begin
            grant[cand[IW-1:0]] = 1'b1;
            idx                 = 2'(cand);
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Up to NREQ writeback requesters (ALU, load data, mult/div) share the port.
// At most one request is granted per cycle, and the winner's address and data are registered.
// Registered outputs:
//   wr_ena/wr_addr feed the active-low 5-to-32 write-select decoder.
//   wr_data goes to the register file.
// Handshake: req_ready is a combinational one-hot grant. A request is accepted in any cycle
// where req_valid[i] & req_ready[i] is high. A requester keeps valid, addr and data stable
// until it is accepted, and it may drop valid at any time before that with no side effect.
// Optional build macro WB_ZERO_FILTER_EN: a granted write to register 0 is consumed
// but never reaches the register file (wr_ena stays low the following cycle).
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic             wb_stall,
   output logic             wr_ena,
   output logic [AW-1:0]    wr_addr,
   output logic [DW-1:0]    wr_data,
   output logic [1:0]       grant_id
);

   logic [1:0]      last_ptr;
   logic [NREQ-1:0] pick_grant;
   logic [1:0]      pick_idx;
   logic            grant_any;
   logic            win_wr;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;

   regfile_wb_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
      .valid    (req_valid),
      .last_ptr (last_ptr),
      .grant    (pick_grant),
      .idx      (pick_idx)
   );

   // A stall masks every grant; a write that is already registered still completes.
   assign req_ready = wb_stall ? '0 : pick_grant;
   assign grant_any = |req_ready;

   // Select the winner's address and data; non-granted requesters are never sampled.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == 2'(i)) begin
            win_addr = req_addr[i*AW +: AW];
            win_data = req_data[i*DW +: DW];
         end
      end
   end

`ifdef WB_ZERO_FILTER_EN
   // A write to $zero is accepted but suppressed before the register file.
   assign win_wr = (win_addr != AW'(REG_ZERO));
`else
   // A write to $zero is passed through; the register file ignores it.
   assign win_wr = 1'b1;
`endif

   // Register the winning write.
   // last_ptr moves only on a grant.
   // The write outputs hold their values when no write is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ptr <= rst_ptr(NREQ);
         wr_ena   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         grant_id <= 2'd0;
      end else begin
         wr_ena <= grant_any & win_wr;
         if (grant_any) begin
            last_ptr <= pick_idx;
         end
         if (grant_any && win_wr) begin
            wr_addr  <= win_addr;
            wr_data  <= win_data;
            grant_id <= pick_idx;
         end
      end
   end

endmodule
